// File: rtl/ahb_params_pkg.sv
// ahb_params_pkg
// Shared AHB bus parameters and types, plus the SRAM slave's FSM state type,
// its wait-state ceiling and a byte-lane helper.
//   ADDR_WIDTH / DATA_WIDTH / NO_OF_MASTERS : bus geometry
//   htrans_t / hsize_t / hburst_t / hresp_t : AHB control encodings
//   sram_state_t, SRAM_MAX_WAIT             : SRAM slave FSM support
//   sram_byte_en()                          : little-endian lane enables
package ahb_params_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int NO_OF_MASTERS = 4;
  localparam int SRAM_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4WORD = 3'd4,
    HSIZE_8WORD = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_t;

  // Byte lanes touched by an aligned access of the given size.
  function automatic logic [3:0] sram_byte_en(hsize_t size, logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem
// Word array with per-byte write enables: synchronous write, combinational read.
//   clk   : clock
//   we    : byte write enables, bit n writes wdata[8n+7:8n]
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module ahb_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  // One independent byte-wide array per lane keeps each write enable on its
  // own storage.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB slave for the SRAM region. Accepts address phases when selected and
// completes the data phase against an internal byte-writable word array,
// with optional wait states and a two-cycle ERROR response for bad accesses.
//   HCLK, HRESETn           : clock, synchronous active-low reset
//   HSEL_SRAM               : decoder select
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT : address phase controls
//   HWDATA                  : write data (data phase)
//   HREADY                  : global bus ready
//   HRDATA/HREADYOUT/HRESP  : registered slave response
//   HSPLIT                  : tied to zero
module ahb_sram_slave
  import ahb_params_pkg::*;
#(
  parameter int                    MEM_DEPTH   = 1024,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL_SRAM,
  input  logic [ADDR_WIDTH-1:0]    HADDR,
  input  htrans_t                  HTRANS,
  input  logic                     HWRITE,
  input  hsize_t                   HSIZE,
  input  hburst_t                  HBURST,
  input  logic [3:0]               HPROT,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  input  logic                     HREADY,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADYOUT,
  output hresp_t                   HRESP,
  output logic [NO_OF_MASTERS-1:0] HSPLIT
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int WS_EFF = (WAIT_STATES > SRAM_MAX_WAIT) ? SRAM_MAX_WAIT : WAIT_STATES;
  localparam logic [3:0] WAIT_INIT = 4'(WS_EFF - 1);
  localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

  sram_state_t        state_reg;
  logic               active_reg;   // ST_IDLE cycle is a completion, not idle
  logic [IDX_W-1:0]   idx_reg;
  logic [1:0]         lane_reg;
  hsize_t             size_reg;
  logic               write_reg;
  logic [3:0]         cnt_reg;
  logic               hreadyout_reg;
  hresp_t             hresp_reg;
  logic [DATA_WIDTH-1:0] hrdata_reg;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  bad_size;
  logic                  misalign;
  logic                  addr_err;
  logic [IDX_W-1:0]      haddr_idx;
  logic                  commit;
  logic [3:0]            mem_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           mem_rdata;
  logic [31:0]           fwd_data;
  logic                  unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT};

  assign accept    = HSEL_SRAM && HREADY &&
                     (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign offset    = HADDR - BASE_ADDR;
  assign in_range  = (HADDR >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign bad_size  = HSIZE > HSIZE_WORD;
  assign misalign  = (HSIZE == HSIZE_HALF && HADDR[0]) ||
                     (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
  assign addr_err  = !in_range || bad_size || misalign;
  assign haddr_idx = offset[IDX_W+1:2];

  // A write commits at the edge that ends its OKAY completion cycle; a reset
  // on that edge discards it.
  assign commit = HRESETn && state_reg == ST_IDLE && active_reg && write_reg;
  assign mem_we = commit ? sram_byte_en(size_reg, lane_reg) : 4'b0000;
  assign rd_idx = (state_reg == ST_WAIT) ? idx_reg : haddr_idx;

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .waddr (idx_reg),
    .wdata (HWDATA),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // HRDATA is registered at the same edge a preceding write commits, so the
  // committing bytes are forwarded to keep write-then-read coherent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign fwd_data[gi*8 +: 8] = (mem_we[gi] && idx_reg == rd_idx) ?
                                 HWDATA[gi*8 +: 8] : mem_rdata[gi*8 +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      active_reg    <= 1'b0;
      idx_reg       <= '0;
      lane_reg      <= 2'b00;
      size_reg      <= HSIZE_BYTE;
      write_reg     <= 1'b0;
      cnt_reg       <= 4'd0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= HRESP_OKAY;
      hrdata_reg    <= '0;
    end else begin
      case (state_reg)
        // Both states present HREADYOUT=1, so a new transfer may start here.
        ST_IDLE, ST_ERR2: begin
          state_reg     <= ST_IDLE;
          active_reg    <= 1'b0;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_OKAY;
          hrdata_reg    <= '0;
          if (accept) begin
            idx_reg   <= haddr_idx;
            lane_reg  <= HADDR[1:0];
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
            if (addr_err) begin
              state_reg     <= ST_ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= HRESP_ERROR;
            end else if (WS_EFF > 0) begin
              state_reg     <= ST_WAIT;
              cnt_reg       <= WAIT_INIT;
              hreadyout_reg <= 1'b0;
            end else begin
              active_reg <= 1'b1;
              if (!HWRITE) begin
                hrdata_reg <= fwd_data;
              end
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg     <= ST_IDLE;
            active_reg    <= 1'b1;
            hreadyout_reg <= 1'b1;
            if (!write_reg) begin
              hrdata_reg <= fwd_data;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_ERROR;
        end
        default: begin
          state_reg     <= ST_IDLE;
          active_reg    <= 1'b0;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_OKAY;
          hrdata_reg    <= '0;
        end
      endcase
    end
  end

  assign HRDATA    = hrdata_reg;
  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;
  assign HSPLIT    = '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// Table-driven check of a zero-wait SRAM slave, plus hand-written sequences
// on a three-wait-state instance for wait timing, errors and reset mid-wait.
module tb_ahb_sram_slave;
  import ahb_params_pkg::*;

  logic        clk;
  logic        rstn;
  logic        sel0, sel3;
  logic [31:0] haddr;
  htrans_t     htrans;
  logic        hwrite;
  hsize_t      hsize;
  hburst_t     hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3;
  hresp_t      resp0, resp3;
  logic [NO_OF_MASTERS-1:0] split0, split3;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL_SRAM(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(ready0), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0), .HSPLIT(split0)
  );

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .HCLK(clk), .HRESETn(rstn), .HSEL_SRAM(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(ready3), .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3), .HSPLIT(split3)
  );

  // One row = one cycle: address phase driven this cycle, HWDATA for the
  // previous row's transfer, and the response expected in the next cycle.
  typedef struct {
    logic        sel;
    htrans_t     trans;
    logic        wr;
    hsize_t      size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    hresp_t      exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mkv(logic s, htrans_t t, logic w, hsize_t z, logic [31:0] a,
                               logic [31:0] wd, logic r, hresp_t rs, logic [31:0] rd);
    vec_t v;
    v.sel = s; v.trans = t; v.wr = w; v.size = z; v.addr = a; v.wdata = wd;
    v.exp_ready = r; v.exp_resp = rs; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s0, input logic s3, input htrans_t t, input logic w,
                       input hsize_t z, input logic [31:0] a);
    sel0 = s0; sel3 = s3; htrans = t; hwrite = w; hsize = z; haddr = a;
  endtask

  task automatic idle_bus();
    drive(1'b0, 1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  // Counts low-HREADYOUT cycles of dut3 from the current cycle, bounded.
  task automatic wait_ready3(input int exp_low, input string name);
    int n;
    n = 0;
    while (ready3 !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk(name, 32'(n), 32'(exp_low));
  endtask

  initial begin
    rstn = 1'b0; hburst = HBURST_SINGLE; hprot = 4'b0011; hwdata = 32'h0;
    idle_bus();

    // Reset
    tick(); tick();
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'(HRESP_OKAY));
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_split0", 32'(split0), 32'h0);
    rstn = 1'b1;
    tick();
    chk("post_rst_ready0", 32'(ready0), 32'd1);
    chk("post_rst_resp0", 32'(resp0), 32'(HRESP_OKAY));
    chk("post_rst_rdata0", rdata0, 32'h0);
    chk("post_rst_split0", 32'(split0), 32'h0);
    chk("post_rst_ready3", 32'(ready3), 32'd1);
    chk("post_rst_split3", 32'(split3), 32'h0);

    // Zero-wait vectors
    vecs[0]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h010,  32'h0,        1, HRESP_OKAY,  32'h0);
    vecs[1]  = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h010,  32'hDEADBEEF, 1, HRESP_OKAY,  32'hDEADBEEF);
    vecs[2]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h020,  32'h0,        1, HRESP_OKAY,  32'h0);
    vecs[3]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,  32'h023,  32'h00000000, 1, HRESP_OKAY,  32'h0);
    vecs[4]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_HALF,  32'h020,  32'hAA000000, 1, HRESP_OKAY,  32'h0);
    vecs[5]  = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h020,  32'h00005555, 1, HRESP_OKAY,  32'hAA005555);
    vecs[6]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h100,  32'h0,        1, HRESP_OKAY,  32'h0);
    vecs[7]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h000,  32'hA5A5A5A5, 1, HRESP_OKAY,  32'h0);
    vecs[8]  = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'hFFC,  32'h11223344, 1, HRESP_OKAY,  32'h0);
    vecs[9]  = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h102,  32'h55667788, 0, HRESP_ERROR, 32'h0);
    vecs[10] = mkv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        1, HRESP_ERROR, 32'h0);
    vecs[11] = mkv(1, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h1000, 32'h0,        0, HRESP_ERROR, 32'h0);
    vecs[12] = mkv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'hFFFFFFFF, 1, HRESP_ERROR, 32'h0);
    vecs[13] = mkv(1, HTRANS_NONSEQ, 1, HSIZE_DWORD, 32'h000,  32'h0,        0, HRESP_ERROR, 32'h0);
    vecs[14] = mkv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'hFFFFFFFF, 1, HRESP_ERROR, 32'h0);
    vecs[15] = mkv(1, HTRANS_NONSEQ, 1, HSIZE_HALF,  32'h101,  32'h0,        0, HRESP_ERROR, 32'h0);
    vecs[16] = mkv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'hFFFFFFFF, 1, HRESP_ERROR, 32'h0);
    vecs[17] = mkv(0, HTRANS_NONSEQ, 1, HSIZE_WORD,  32'h000,  32'h0,        1, HRESP_OKAY,  32'h0);
    vecs[18] = mkv(1, HTRANS_BUSY,   1, HSIZE_WORD,  32'h000,  32'hFFFFFFFF, 1, HRESP_OKAY,  32'h0);
    vecs[19] = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h000,  32'hFFFFFFFF, 1, HRESP_OKAY,  32'h11223344);
    vecs[20] = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'h100,  32'h0,        1, HRESP_OKAY,  32'hA5A5A5A5);
    vecs[21] = mkv(1, HTRANS_NONSEQ, 0, HSIZE_WORD,  32'hFFC,  32'h0,        1, HRESP_OKAY,  32'h55667788);
    vecs[22] = mkv(1, HTRANS_IDLE,   0, HSIZE_WORD,  32'h0,    32'h0,        1, HRESP_OKAY,  32'h0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].sel, 1'b0, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr);
      hwdata = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(ready0), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_resp", i), 32'(resp0), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_rdata", i), rdata0, vecs[i].exp_rdata);
    end
    idle_bus();
    tick();

    // Wait states: writes to 0x10/0x14, read 0x10, SEQ 0x14 in completion cycle.
    // HSEL is dropped during each data phase; the transfer must still finish.
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    idle_bus(); hwdata = 32'h0BADCAFE;
    wait_ready3(3, "ws_wr10_low");
    chk("ws_wr10_resp", 32'(resp3), 32'(HRESP_OKAY));
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h14);
    tick();
    idle_bus(); hwdata = 32'h13572468;
    wait_ready3(3, "ws_wr14_low");
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    idle_bus();
    chk("ws_rd10_wait_rdata", rdata3, 32'h0);
    wait_ready3(3, "ws_rd10_low");
    chk("ws_rd10_rdata", rdata3, 32'h0BADCAFE);
    chk("ws_rd10_resp", 32'(resp3), 32'(HRESP_OKAY));
    drive(1'b0, 1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h14);
    tick();
    idle_bus();
    chk("ws_seq14_accepted", 32'(ready3), 32'd0);
    wait_ready3(3, "ws_seq14_low");
    chk("ws_seq14_rdata", rdata3, 32'h13572468);
    tick();
    chk("ws_after_rdata", rdata3, 32'h0);

    // ERROR is two cycles even with wait states configured.
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h102);
    tick();
    idle_bus();
    chk("ws_err_c1_ready", 32'(ready3), 32'd0);
    chk("ws_err_c1_resp", 32'(resp3), 32'(HRESP_ERROR));
    chk("ws_err_c1_rdata", rdata3, 32'h0);
    tick();
    chk("ws_err_c2_ready", 32'(ready3), 32'd1);
    chk("ws_err_c2_resp", 32'(resp3), 32'(HRESP_ERROR));
    tick();
    chk("ws_err_done_resp", 32'(resp3), 32'(HRESP_OKAY));

    // Reset during a wait state discards the pending write.
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
    tick();
    idle_bus(); hwdata = 32'h0000AAAA;
    wait_ready3(3, "rw_old_low");
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
    tick();
    idle_bus(); hwdata = 32'h12345678;
    tick();
    chk("rw_in_wait", 32'(ready3), 32'd0);
    rstn = 1'b0;
    tick();
    chk("rw_rst_ready", 32'(ready3), 32'd1);
    chk("rw_rst_resp", 32'(resp3), 32'(HRESP_OKAY));
    chk("rw_rst_rdata", rdata3, 32'h0);
    rstn = 1'b1;
    tick(); tick(); tick(); tick();
    drive(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30);
    tick();
    idle_bus();
    wait_ready3(3, "rw_rd_low");
    chk("rw_rd_old_data", rdata3, 32'h0000AAAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
